memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Parametrised RAM arbiter between the per-core cache controllers and the single-ported RAM in the multicore build. Generalises the single-core instruction/data mux to `CPUS` cores, with a registered grant that is held for a whole RAM transaction. Data requests have priority over instruction requests. Round-robin fairness is kept across cores within each class.

## Interface
Parameters:
- `CPUS`, 2, number of cores; each core owns one instruction and one data channel.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, word width.

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  asynchronous active-low reset.
- `iREN`  in  CPUS  per-core instruction read request.
- `dREN`, `dWEN`  in  CPUS  per-core data read and write requests.
- `iaddr`, `daddr`  in  CPUS×ADDR_W  per-core addresses.
- `dstore`  in  CPUS×DATA_W  per-core write data.
- `iwait`, `dwait`  out  CPUS  per-core stall; low for exactly the completing cycle.
- `iload`, `dload`  out  CPUS×DATA_W  per-core read data; valid only while the matching wait is low, 0 otherwise.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`  out  ADDR_W  RAM address.
- `ramstore`  out  DATA_W  RAM write data.
- `ramload`  in  DATA_W  RAM read data.
- `ramstate`  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.
- `ram_err`  out  1  one-cycle pulse when the granted transaction sees ERROR.

## Operation
- FSM states:
  - IDLE: no grant. RAM strobes, `ramaddr`, `ramstore` = 0. All waits = 1.
  - GRANT: the registered `gnt_cpu` and `gnt_isd` (data vs. instruction) drive the RAM.
- IDLE → GRANT when any request is active. Arbitration, evaluated in IDLE:
  - Any `dREN|dWEN` present: pick the data channel at or after `dptr`, cyclically.
  - Otherwise pick the instruction channel at or after `iptr`.
- In GRANT, the RAM is driven from the granted channel:
  - Data grant with `dWEN`: `ramWEN=1`, `ramREN=0`, `ramstore=dstore[gnt]`.
  - Data grant with `dREN` only: `ramREN=1`.
  - Instruction grant: `ramREN=1`.
  - `dWEN` and `dREN` both high on the same core: write wins.
- In GRANT with `ramstate==ACCESS`: the granted wait = 0 combinationally, and `load = ramload` for reads. Next edge goes to IDLE, and the class pointer becomes `gnt_cpu+1` mod CPUS.
- In GRANT with `ramstate==ERROR`: pulse `ram_err`, keep waits high, stay in GRANT (retry).
- FREE or BUSY: hold state, waits high.
- Granted requester drops its request before ACCESS: abort to IDLE next edge, pointer unchanged, RAM strobes 0 from that edge.
- Ungranted channels keep wait = 1 and load = 0 at all times.
- Requests from other cores arriving during a grant do not preempt it. Data priority is applied only at the next IDLE arbitration.

## Timing
- Reset (async): state IDLE, `dptr = iptr = 0`, grant regs 0, all waits 1, all loads 0, RAM outputs 0, `ram_err` 0.
- Request seen in cycle n → RAM strobes in cycle n+1 → wait low in the first GRANT cycle with ACCESS.
  - Minimum 2 cycles per access.
  - One idle cycle between back-to-back grants.
- Reset asserted mid-transaction: outputs return to reset values immediately and the transaction is dropped. The requester re-issues after reset.
- Waits and loads are combinational from `ramstate` in GRANT. RAM strobes, address and store data are combinational from the registered grant only, never from the arbitration logic.

## Structure
- `cpu_types_pkg` holds `ramstate_t` (FREE/BUSY/ACCESS/ERROR), `word_t`, and a new `arb_state_t` (IDLE, GRANT).
- One sub-module, `rr_picker #(N)`:
  - Inputs: request vector, pointer.
  - Outputs: valid, index. Purely combinational.
  - Instantiated twice, once for data and once for instruction.
- FSM, pointers and output muxing live in `memory_arbiter`.

## Test plan
- Single core 0 `iREN`, `iaddr=0x40`, ACCESS after 2 BUSY cycles → `ramREN=1`, `ramaddr=0x40` from cycle 1; `iwait[0]=0` in cycle 3 only, `iload[0]=ramload`.
- Core 0 `iREN` and core 1 `dWEN` together, `daddr=0x80`, `dstore=0xDEADBEEF` → core 1 data granted first (`ramWEN=1`, `ramstore=0xDEADBEEF`); core 0 instruction granted after.
- Both cores hold `dREN` continuously, ACCESS every GRANT cycle → grants alternate 0,1,0,1; each `dwait` is low once per 4 cycles.
- Core 1 `dWEN` and `dREN` both high → `ramWEN=1`, `ramREN=0`.
- ERROR for 2 cycles then ACCESS → two `ram_err` pulses, grant held, then completion.
- `nRST` low during GRANT → all waits 1, RAM strobes 0 in the same cycle; after release, state IDLE and pointers 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared RAM-side types for the multicore memory path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: RAM status encoding, machine word, arbiter state encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr_i, cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
// Ports: req_i (request vector), ptr_i (search start) -> vld_o (any request),
//        idx_o (chosen index). N must be at least 2.
module rr_picker #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  int           s;
  logic [W-1:0] cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    s     = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // Wrap ptr+k back into 0..N-1 without relying on a power-of-two N.
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      cand = W'(s);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates CPUS cores' instruction/data channels onto one single-ported RAM.
// Latency: request seen in cycle n -> RAM strobes in n+1; completion in the first ACCESS cycle; one idle cycle between grants.
// Backpressure: ungranted channels see wait=1 until their transaction completes; a grant is never preempted.
// Ports: CLK/nRST; per-core iREN/dREN/dWEN, iaddr/daddr/dstore in; iwait/dwait, iload/dload out;
//        RAM side ramREN/ramWEN/ramaddr/ramstore out, ramload/ramstate in; ram_err pulse out.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [CPUS-1:0]               iREN,
  input  logic [CPUS-1:0]               dREN,
  input  logic [CPUS-1:0]               dWEN,
  input  logic [CPUS-1:0][ADDR_W-1:0]   iaddr,
  input  logic [CPUS-1:0][ADDR_W-1:0]   daddr,
  input  logic [CPUS-1:0][DATA_W-1:0]   dstore,
  output logic [CPUS-1:0]               iwait,
  output logic [CPUS-1:0]               dwait,
  output logic [CPUS-1:0][DATA_W-1:0]   iload,
  output logic [CPUS-1:0][DATA_W-1:0]   dload,
  output logic                          ramREN,
  output logic                          ramWEN,
  output logic [ADDR_W-1:0]             ramaddr,
  output logic [DATA_W-1:0]             ramstore,
  input  logic [DATA_W-1:0]             ramload,
  input  ramstate_t                     ramstate,
  output logic                          ram_err
);

  localparam int PW = $clog2(CPUS);

  arb_state_t    state_q, state_d;
  logic [PW-1:0] gnt_cpu_q, gnt_cpu_d;
  logic          gnt_isd_q, gnt_isd_d;  // 1: data channel granted, 0: instruction
  logic [PW-1:0] dptr_q, dptr_d;
  logic [PW-1:0] iptr_q, iptr_d;

  logic          d_vld, i_vld;
  logic [PW-1:0] d_idx, i_idx;
  logic          g_dren, g_dwen, g_req, in_grant, done;
  logic [PW-1:0] gnt_nxt;

  rr_picker #(.N(CPUS)) u_dpick (
    .req_i (dREN | dWEN),
    .ptr_i (dptr_q),
    .vld_o (d_vld),
    .idx_o (d_idx)
  );

  rr_picker #(.N(CPUS)) u_ipick (
    .req_i (iREN),
    .ptr_i (iptr_q),
    .vld_o (i_vld),
    .idx_o (i_idx)
  );

  // Granted channel's live request; dropping it aborts the transaction.
  always_comb begin
    g_dren   = dREN[gnt_cpu_q];
    g_dwen   = dWEN[gnt_cpu_q];
    g_req    = gnt_isd_q ? (g_dren | g_dwen) : iREN[gnt_cpu_q];
    in_grant = (state_q == GRANT);
    done     = in_grant && g_req && (ramstate == ACCESS);
    gnt_nxt  = (gnt_cpu_q == PW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      gnt_cpu_q <= '0;
      gnt_isd_q <= 1'b0;
      dptr_q    <= '0;
      iptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_cpu_q <= gnt_cpu_d;
      gnt_isd_q <= gnt_isd_d;
      dptr_q    <= dptr_d;
      iptr_q    <= iptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_cpu_d = gnt_cpu_q;
    gnt_isd_d = gnt_isd_q;
    dptr_d    = dptr_q;
    iptr_d    = iptr_q;
    case (state_q)
      IDLE: begin
        if (d_vld) begin
          state_d   = GRANT;
          gnt_cpu_d = d_idx;
          gnt_isd_d = 1'b1;
        end else if (i_vld) begin
          state_d   = GRANT;
          gnt_cpu_d = i_idx;
          gnt_isd_d = 1'b0;
        end
      end
      GRANT: begin
        if (!g_req) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          state_d = IDLE;
          if (gnt_isd_q) dptr_d = gnt_nxt;
          else           iptr_d = gnt_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side depends only on the registered grant (plus the granted
  // channel's own request/address), never on the pickers.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ram_err  = in_grant && g_req && (ramstate == ERROR);
    if (in_grant) begin
      if (gnt_isd_q) begin
        ramWEN  = g_dwen;
        ramREN  = g_dren & ~g_dwen;  // write wins over read
        ramaddr = daddr[gnt_cpu_q];
        if (g_dwen) ramstore = dstore[gnt_cpu_q];
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gnt_cpu_q];
      end
    end
    if (done) begin
      if (gnt_isd_q) begin
        dwait[gnt_cpu_q] = 1'b0;
        if (!g_dwen) dload[gnt_cpu_q] = ramload;
      end else begin
        iwait[gnt_cpu_q] = 1'b0;
        iload[gnt_cpu_q] = ramload;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  localparam logic [31:0] A_I0 = 32'h0000_0040;
  localparam logic [31:0] A_I1 = 32'h0000_0044;
  localparam logic [31:0] A_D0 = 32'h0000_0100;
  localparam logic [31:0] A_D1 = 32'h0000_0080;
  localparam logic [31:0] S0   = 32'h1111_1111;
  localparam logic [31:0] S1   = 32'hDEAD_BEEF;

  logic                      CLK = 1'b0;
  logic                      nRST;
  logic [CPUS-1:0]           iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][AW-1:0]   iaddr, daddr;
  logic [CPUS-1:0][DW-1:0]   dstore, iload, dload;
  logic                      ramREN, ramWEN, ram_err;
  logic [AW-1:0]             ramaddr;
  logic [DW-1:0]             ramstore, ramload;
  ramstate_t                 ramstate;

  memory_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic [1:0]  iren, dren, dwen;
    ramstate_t   rs;
    logic [31:0] rload;
    logic [1:0]  e_iw, e_dw;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_err;
    logic [3:0]  e_ldm;  // which load carries rload: {d1,d0,i1,i0}
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic vec_t mk(logic rst_n, logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen,
                              ramstate_t rs, logic [31:0] rload, logic [1:0] e_iw, logic [1:0] e_dw,
                              logic e_ren, logic e_wen, logic [31:0] e_addr, logic [31:0] e_store,
                              logic e_err, logic [3:0] e_ldm);
    vec_t v;
    v.rst_n = rst_n; v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.rload = rload;
    v.e_iw = e_iw; v.e_dw = e_dw; v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr;
    v.e_store = e_store; v.e_err = e_err; v.e_ldm = e_ldm;
    return v;
  endfunction

  function automatic vec_t idle(logic [1:0] iren, logic [1:0] dren, logic [1:0] dwen, ramstate_t rs);
    return mk(1'b1, iren, dren, dwen, rs, 32'h0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'b0000);
  endfunction

  task automatic drive(input vec_t v);
    nRST     = v.rst_n;
    iREN     = v.iren;
    dREN     = v.dren;
    dWEN     = v.dwen;
    ramstate = v.rs;
    ramload  = v.rload;
  endtask

  task automatic check(input vec_t v, input string nm);
    logic [31:0] ei0, ei1, ed0, ed1;
    ei0 = v.e_ldm[0] ? v.rload : 32'h0;
    ei1 = v.e_ldm[1] ? v.rload : 32'h0;
    ed0 = v.e_ldm[2] ? v.rload : 32'h0;
    ed1 = v.e_ldm[3] ? v.rload : 32'h0;
    nvec++;
    if (iwait !== v.e_iw || dwait !== v.e_dw || ramREN !== v.e_ren || ramWEN !== v.e_wen ||
        ramaddr !== v.e_addr || ramstore !== v.e_store || ram_err !== v.e_err ||
        iload[0] !== ei0 || iload[1] !== ei1 || dload[0] !== ed0 || dload[1] !== ed1) begin
      nbad++;
      $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b addr=%h st=%h err=%b ld=%h/%h/%h/%h; want iw=%b dw=%b ren=%b wen=%b addr=%h st=%h err=%b ld=%h/%h/%h/%h",
               nm, iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err,
               iload[0], iload[1], dload[0], dload[1],
               v.e_iw, v.e_dw, v.e_ren, v.e_wen, v.e_addr, v.e_store, v.e_err, ei0, ei1, ed0, ed1);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge CLK);
    drive(v);
    #1;
    check(v, nm);
  endtask

  initial begin
    vec_t v;
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE; ramload = '0;
    iaddr[0] = A_I0; iaddr[1] = A_I1;
    daddr[0] = A_D0; daddr[1] = A_D1;
    dstore[0] = S0;  dstore[1] = S1;

    // reset state
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, FREE, 32'h0, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0, 0, 4'b0000));
    // core0 ifetch, two BUSY then ACCESS
    tbl.push_back(idle(2'b01, 2'b00, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, BUSY,   32'h0,       2'b11, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0000));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, BUSY,   32'h0,       2'b11, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0000));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, ACCESS, 32'h12345678, 2'b10, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0001));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, FREE));
    // core0 ifetch vs core1 write: data first, then instruction
    tbl.push_back(idle(2'b01, 2'b00, 2'b10, FREE));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b10, ACCESS, 32'h13572468, 2'b11, 2'b01, 0, 1, A_D1, S1, 0, 4'b0000));
    tbl.push_back(idle(2'b01, 2'b00, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, ACCESS, 32'h0BADF00D, 2'b10, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0001));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, FREE));
    // core1 read+write together: write wins
    tbl.push_back(idle(2'b00, 2'b10, 2'b10, FREE));
    tbl.push_back(mk(1, 2'b00, 2'b10, 2'b10, BUSY,   32'h0,       2'b11, 2'b11, 0, 1, A_D1, S1, 0, 4'b0000));
    tbl.push_back(mk(1, 2'b00, 2'b10, 2'b10, ACCESS, 32'h2468ACE0, 2'b11, 2'b01, 0, 1, A_D1, S1, 0, 4'b0000));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, FREE));
    // ERROR twice then ACCESS on core0 data read
    tbl.push_back(idle(2'b00, 2'b01, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, ERROR,  32'hFFFFFFFF, 2'b11, 2'b11, 1, 0, A_D0, 32'h0, 1, 4'b0000));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, ERROR,  32'hEEEEEEEE, 2'b11, 2'b11, 1, 0, A_D0, 32'h0, 1, 4'b0000));
    tbl.push_back(mk(1, 2'b00, 2'b01, 2'b00, ACCESS, 32'h55AA55AA, 2'b11, 2'b10, 1, 0, A_D0, 32'h0, 0, 4'b0100));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, FREE));
    // core1 ifetch aborted, pointer must stay at core1
    tbl.push_back(idle(2'b10, 2'b00, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b10, 2'b00, 2'b00, BUSY,   32'h0,       2'b11, 2'b11, 1, 0, A_I1, 32'h0, 0, 4'b0000));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, BUSY,   32'h0,       2'b11, 2'b11, 1, 0, A_I1, 32'h0, 0, 4'b0000));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, BUSY));
    tbl.push_back(idle(2'b11, 2'b00, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, ACCESS, 32'h77777777, 2'b01, 2'b11, 1, 0, A_I1, 32'h0, 0, 4'b0010));
    tbl.push_back(idle(2'b11, 2'b00, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, ACCESS, 32'h88888888, 2'b10, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0001));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, FREE));
    // data request arriving mid-grant does not preempt
    tbl.push_back(idle(2'b01, 2'b00, 2'b00, FREE));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b10, BUSY,   32'h0,       2'b11, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0000));
    tbl.push_back(mk(1, 2'b01, 2'b00, 2'b10, ACCESS, 32'h99999999, 2'b10, 2'b11, 1, 0, A_I0, 32'h0, 0, 4'b0001));
    tbl.push_back(idle(2'b00, 2'b00, 2'b10, FREE));
    tbl.push_back(mk(1, 2'b00, 2'b00, 2'b10, ACCESS, 32'h31415926, 2'b11, 2'b01, 0, 1, A_D1, S1, 0, 4'b0000));
    tbl.push_back(idle(2'b00, 2'b00, 2'b00, FREE));

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 1) begin
        @(negedge CLK);
        nRST = 1'b1;
      end
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Both cores stream data reads, ACCESS every cycle: 0,1,0,1 with idle gaps.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        v = idle(2'b00, 2'b11, 2'b00, ACCESS);
      else if (k % 4 == 1)
        v = mk(1, 2'b00, 2'b11, 2'b00, ACCESS, 32'hA0000000 + k, 2'b11, 2'b10, 1, 0, A_D0, 32'h0, 0, 4'b0100);
      else
        v = mk(1, 2'b00, 2'b11, 2'b00, ACCESS, 32'hA0000000 + k, 2'b11, 2'b01, 1, 0, A_D1, 32'h0, 0, 4'b1000);
      v.rload = 32'hA0000000 + k;
      step(v, $sformatf("alt%0d", k));
    end

    // Advance dptr to 1, then reset in the middle of a core1 grant.
    step(idle(2'b00, 2'b01, 2'b00, FREE), "rst_pre0");
    step(mk(1, 2'b00, 2'b01, 2'b00, ACCESS, 32'hC0FFEE00, 2'b11, 2'b10, 1, 0, A_D0, 32'h0, 0, 4'b0100), "rst_pre1");
    step(idle(2'b00, 2'b10, 2'b00, FREE), "rst_pre2");
    step(mk(1, 2'b00, 2'b10, 2'b00, BUSY, 32'h0, 2'b11, 2'b11, 1, 0, A_D1, 32'h0, 0, 4'b0000), "rst_pre3");
    #2;
    v = mk(0, 2'b00, 2'b10, 2'b00, ACCESS, 32'h5A5A5A5A, 2'b11, 2'b11, 0, 0, 32'h0, 32'h0, 0, 4'b0000);
    drive(v);
    #1;
    check(v, "rst_async");
    step(v, "rst_hold");
    // After release: IDLE, and dptr back at 0 so core0 wins the tie.
    step(idle(2'b00, 2'b11, 2'b00, FREE), "rst_release");
    step(mk(1, 2'b00, 2'b11, 2'b00, ACCESS, 32'h600DCAFE, 2'b11, 2'b10, 1, 0, A_D0, 32'h0, 0, 4'b0100), "rst_ptr0");
    step(idle(2'b00, 2'b00, 2'b00, FREE), "rst_post");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
